// File: rtl/countup_timer_pkg.sv
// Shared types and constants for the two-digit BCD count-up timer.
package countup_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [14:0] ENDLED_ON = 15'h7FFF;

endpackage

// File: rtl/countup_timer_if.sv
// Button input and display outputs of the count-up timer, bundled for the board glue.
interface countup_timer_if;

  logic        in;
  logic [2:0]  a;
  logic [3:0]  b;
  logic        stateled;
  logic [14:0] endled;

  modport master (
    output in,
    input  a,
    input  b,
    input  stateled,
    input  endled
  );

  modport slave (
    input  in,
    output a,
    output b,
    output stateled,
    output endled
  );

endinterface

// File: rtl/countup_timer_tick_gen.sv
// Prescaler: emits one tick every TickDiv enabled cycles; holds its value while disabled.
module countup_timer_tick_gen #(
  parameter int unsigned TickDiv = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned Width = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [Width-1:0] Last = Width'(TickDiv - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == Last);

  // Next prescaler value: clear wins, otherwise count and wrap only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + Width'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countup_timer.sv
// Two-digit BCD count-up timer with start/pause/resume button and done LED bank.
module countup_timer
  import countup_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned LIMIT_TENS = 3,
  parameter int unsigned LIMIT_ONES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  countup_timer_if.slave  bus
);

  if (TICK_DIV == 0 || LIMIT_TENS > 7 || LIMIT_ONES > 9 ||
      (LIMIT_TENS == 0 && LIMIT_ONES == 0)) begin : gen_param_check
    $error("countup_timer: illegal TICK_DIV or limit parameters");
  end

  localparam logic [2:0] LimTens = 3'(LIMIT_TENS);
  localparam logic [3:0] LimOnes = 4'(LIMIT_ONES);

  state_e      state_q, state_d;
  logic        in_d_q;
  logic [2:0]  a_q, a_d, a_inc;
  logic [3:0]  b_q, b_d, b_inc;
  logic        stateled_q;
  logic [14:0] endled_q;
  logic        press, run, tick, inc, hit, clear;

  assign press = bus.in & ~in_d_q;
  assign run   = (state_q == StRun);
  assign clear = (state_q == StIdle) & press;
  assign inc   = run & tick;

  countup_timer_tick_gen #(
    .TickDiv (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (run),
    .clear  (clear),
    .tick   (tick)
  );

  // BCD increment and limit compare on the post-increment value.
  always_comb begin
    a_inc = a_q;
    b_inc = b_q + 4'd1;
    if (b_q == BCD_MAX) begin
      b_inc = 4'd0;
      a_inc = a_q + 3'd1;
    end
    hit = inc & (a_inc == LimTens) & (b_inc == LimOnes);
  end

  // Next state and digit values; reaching the limit overrides a coincident pause.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (inc) begin
      a_d = a_inc;
      b_d = b_inc;
    end
    unique case (state_q)
      StIdle:  if (press) state_d = StRun;
      StRun: begin
        if (hit) begin
          state_d = StDone;
        end else if (press) begin
          state_d = StPause;
        end
      end
      StPause: if (press) state_d = StRun;
      StDone: begin
        if (press) begin
          state_d = StIdle;
          a_d     = 3'd0;
          b_d     = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, digits and LED outputs; LEDs follow the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_d_q     <= 1'b1;
      a_q        <= 3'd0;
      b_q        <= 4'd0;
      stateled_q <= 1'b0;
      endled_q   <= 15'd0;
    end else begin
      state_q    <= state_d;
      in_d_q     <= bus.in;
      a_q        <= a_d;
      b_q        <= b_d;
      stateled_q <= (state_d == StRun);
      endled_q   <= (state_d == StDone) ? ENDLED_ON : 15'd0;
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.stateled = stateled_q;
  assign bus.endled   = endled_q;

endmodule

// File: tb/tb_countup_timer.sv
// Directed bench for countup_timer: TICK_DIV=4 / limit 30 and TICK_DIV=1 / limit 05.
module tb_countup_timer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fails;

  countup_timer_if bus4 ();
  countup_timer_if bus1 ();

  countup_timer #(
    .TICK_DIV   (4),
    .LIMIT_TENS (3),
    .LIMIT_ONES (0)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  countup_timer #(
    .TICK_DIV   (1),
    .LIMIT_TENS (0),
    .LIMIT_ONES (5)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [2:0] ea, input logic [3:0] eb,
                        input logic es, input logic [14:0] ee);
    check({tag, ".a"}, 32'(bus4.a), 32'(ea));
    check({tag, ".b"}, 32'(bus4.b), 32'(eb));
    check({tag, ".stateled"}, 32'(bus4.stateled), 32'(es));
    check({tag, ".endled"}, 32'(bus4.endled), 32'(ee));
  endtask

  initial begin
    n_tests  = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    bus4.in  = 1'b1;
    bus1.in  = 1'b0;

    // Reset with button held, then keep holding: must stay idle.
    step(2);
    check4("in_reset", 3'd0, 4'd0, 1'b0, 15'h0);
    rst_n = 1'b1;
    step(10);
    check4("held_after_reset", 3'd0, 4'd0, 1'b0, 15'h0);
    bus4.in = 1'b0;
    step(1);

    // Single press and count cadence.
    bus4.in = 1'b1;
    step(1);
    check4("start", 3'd0, 4'd0, 1'b1, 15'h0);
    bus4.in = 1'b0;
    step(3);
    check4("edge3", 3'd0, 4'd0, 1'b1, 15'h0);
    step(1);
    check4("edge4", 3'd0, 4'd1, 1'b1, 15'h0);
    step(32);
    check4("edge36", 3'd0, 4'd9, 1'b1, 15'h0);
    step(4);
    check4("edge40", 3'd1, 4'd0, 1'b1, 15'h0);
    step(28);
    check4("edge68", 3'd1, 4'd7, 1'b1, 15'h0);

    // Asynchronous reset mid-run, observed before any clock edge.
    rst_n = 1'b0;
    #2;
    check4("async_rst", 3'd0, 4'd0, 1'b0, 15'h0);
    #3;
    rst_n = 1'b1;
    step(1);

    // Pause at 0/5 with a partial interval, then resume.
    bus4.in = 1'b1;
    step(1);
    bus4.in = 1'b0;
    step(20);
    check4("at05", 3'd0, 4'd5, 1'b1, 15'h0);
    step(2);
    bus4.in = 1'b1;
    step(1);
    check4("paused", 3'd0, 4'd5, 1'b0, 15'h0);
    bus4.in = 1'b0;
    step(7);
    check4("pause_frozen", 3'd0, 4'd5, 1'b0, 15'h0);
    bus4.in = 1'b1;
    step(1);
    check4("resumed", 3'd0, 4'd5, 1'b1, 15'h0);
    bus4.in = 1'b0;
    step(1);
    check4("resume_tick", 3'd0, 4'd6, 1'b1, 15'h0);

    // Press coincident with the tick reaching the limit: DONE wins.
    step(92);
    check4("at29", 3'd2, 4'd9, 1'b1, 15'h0);
    step(3);
    bus4.in = 1'b1;
    step(1);
    check4("press_at_limit", 3'd3, 4'd0, 1'b0, 15'h7FFF);
    bus4.in = 1'b0;
    step(5);
    check4("done_frozen", 3'd3, 4'd0, 1'b0, 15'h7FFF);
    bus4.in = 1'b1;
    step(1);
    check4("done_to_idle", 3'd0, 4'd0, 1'b0, 15'h0);
    bus4.in = 1'b0;
    step(1);

    // Uninterrupted run: limit lands on the 120th RUN edge.
    bus4.in = 1'b1;
    step(1);
    bus4.in = 1'b0;
    step(119);
    check4("edge119", 3'd2, 4'd9, 1'b1, 15'h0);
    step(1);
    check4("edge120", 3'd3, 4'd0, 1'b0, 15'h7FFF);

    // TICK_DIV=1, limit 05: five RUN cycles reach DONE.
    bus1.in = 1'b1;
    step(1);
    check("d1.start.stateled", 32'(bus1.stateled), 32'd1);
    check("d1.start.b", 32'(bus1.b), 32'd0);
    bus1.in = 1'b0;
    step(4);
    check("d1.edge4.b", 32'(bus1.b), 32'd4);
    check("d1.edge4.endled", 32'(bus1.endled), 32'h0);
    step(1);
    check("d1.edge5.b", 32'(bus1.b), 32'd5);
    check("d1.edge5.a", 32'(bus1.a), 32'd0);
    check("d1.edge5.endled", 32'(bus1.endled), 32'h7FFF);
    check("d1.edge5.stateled", 32'(bus1.stateled), 32'd0);
    step(3);
    check("d1.hold.b", 32'(bus1.b), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
